imply_stack: RTL and testbench
==============================

Name: imply_stack

Overview:
- LIFO buffer of implied variable assignments, directly downstream of the conflict detector.
- Captures each non-conflicting implication (var index + value) pushed by the detector.
- Hands implications back to the solver one at a time via a pop handshake.
- On backtrack, drains all held entries one per cycle as unassign events, so the solver and assignment memories can clear those variables.

Parameters:
- MAX_VARS_BITS, 9, width of a variable index.
- DEPTH, 512, number of stack entries; must be a power of two, at most 2^MAX_VARS_BITS.
- DEPTH_BITS, 9, log2(DEPTH).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clock.
- push_en  input  1  push request from conflict detector.
- push_var_idx  input  MAX_VARS_BITS  implied variable index.
- push_val  input  1  implied value.
- pop_req  input  1  solver requests the top entry.
- flush  input  1  backtrack request; drain the whole stack.
- pop_valid  output  1  registered; pop_var_idx/pop_val are valid this cycle.
- pop_var_idx  output  MAX_VARS_BITS  registered popped index.
- pop_val  output  1  registered popped value.
- unassign_valid  output  1  drain output is valid this cycle.
- unassign_var_idx  output  MAX_VARS_BITS  variable being undone.
- busy  output  1  high while draining.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag; a push was dropped.
- count  output  DEPTH_BITS+1  current number of entries.

Behaviour:
- Storage: mem[DEPTH] of {var_idx, val}; stack pointer sp (DEPTH_BITS+1 bits). count = sp. empty and full decode combinationally from sp.
- Reset (reset==0 at posedge):
  - sp=0, state=IDLE.
  - pop_valid=0, pop_var_idx=0, pop_val=0, overflow=0.
  - Memory contents are don't-care.
  - Reset aborts a drain in progress; no further unassign outputs appear.
- FSM states: IDLE and DRAIN.
- IDLE, evaluated in priority order at each posedge:
  1. flush=1 and sp>0: go to DRAIN. push/pop this cycle are ignored; an ignored push sets overflow. pop_valid=0 next cycle.
  2. flush=1 and sp==0: stay IDLE, no unassign output. push/pop are still ignored (ignored push sets overflow).
  3. push_en and pop_req together: bypass. Next cycle pop_valid=1 carrying the pushed entry; sp and mem unchanged. Applies when empty and when full; no overflow.
  4. push_en only: if !full, mem[sp]<=entry and sp+1. If full, entry dropped and overflow<=1.
  5. pop_req only: if !empty, next cycle pop_valid=1 with mem[sp-1], and sp-1. If empty, pop_valid=0 next cycle, no state change.
  6. pop_valid is 0 in any cycle that does not follow a successful pop.
- DRAIN:
  - Combinational outputs: unassign_valid=1, unassign_var_idx=mem[sp-1], busy=1.
  - Each posedge: sp-1. When sp==1 at the edge, return to IDLE.
  - Timing: flush sampled at edge T with count N gives unassign outputs in cycles T+1..T+N, top entry first. busy is high over the same cycles; IDLE accepts requests again from edge T+N+1.
  - push_en during DRAIN is dropped and sets overflow; pop_req and flush are ignored.
- IDLE outputs: unassign_valid=0, busy=0, unassign_var_idx=0.
- overflow clears only on reset.
- Latency: push to visibility in count is 1 cycle; pop_req to pop_valid is 1 cycle; flush to first unassign is 1 cycle.
- sp arithmetic is unsigned; sp never wraps. Push is guarded by full, pop and drain are guarded by empty.

Test Plan:
- Reset low 2 cycles, then release → count=0, empty=1, pop_valid=0, overflow=0, busy=0.
- Push (5,1),(9,0),(3,1) in consecutive cycles; then pop_req for 3 cycles → pop_valid in the following 3 cycles with (3,1),(9,0),(5,1); count ends at 0; a 4th pop gives pop_valid=0.
- With DEPTH=4: push 5 entries → full=1 after the 4th push; 5th push dropped, overflow=1, count=4. Same-cycle push (7,0) + pop → pop returns (7,0), count stays 4.
- Push (1,0),(2,1),(4,0); flush at T → unassign_var_idx 4,2,1 in cycles T+1..T+3; busy high for those 3 cycles; push_en at T+2 dropped with overflow=1; count=0 at T+4.
- Flush while empty → no unassign_valid, busy stays 0. Push+pop with empty stack → pop_valid=1 next cycle with the pushed entry, count stays 0.
- Push 3 entries, flush, assert reset at T+2 (mid-drain) → from T+3: busy=0, count=0, unassign_valid=0, overflow=0.

Source files
------------

// File: rtl/imply_stack.sv
// imply_stack: LIFO of implied variable assignments fed by the conflict detector.
// Implications are pushed one per cycle and popped back to the solver through a
// registered pop handshake. On backtrack (flush) every held entry is drained,
// top first, one per cycle as an unassign event.
//
// Ports:
//   clock            system clock, all state changes on posedge
//   reset            synchronous active-low reset
//   push_en          push request (push_var_idx, push_val)
//   pop_req          request the top entry; result one cycle later on pop_*
//   flush            backtrack: drain the whole stack
//   pop_valid        registered, pop_var_idx/pop_val valid this cycle
//   unassign_valid   drain output valid (combinational from state)
//   unassign_var_idx variable being undone this cycle
//   busy             high while draining
//   empty/full       decoded from the stack pointer
//   overflow         sticky, a push was dropped
//   count            current number of entries
module imply_stack #(
  parameter int unsigned MAX_VARS_BITS = 9,
  parameter int unsigned DEPTH         = 512,
  parameter int unsigned DEPTH_BITS    = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_en,
  input  logic [MAX_VARS_BITS-1:0] push_var_idx,
  input  logic                     push_val,
  input  logic                     pop_req,
  input  logic                     flush,
  output logic                     pop_valid,
  output logic [MAX_VARS_BITS-1:0] pop_var_idx,
  output logic                     pop_val,
  output logic                     unassign_valid,
  output logic [MAX_VARS_BITS-1:0] unassign_var_idx,
  output logic                     busy,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [DEPTH_BITS:0]      count
);

  localparam int unsigned SP_W    = DEPTH_BITS + 1;
  localparam int unsigned ENTRY_W = MAX_VARS_BITS + 1;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [SP_W-1:0]         sp;
  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0]   top_idx;
  logic [ENTRY_W-1:0]      top_entry;
  logic                    mem_we;

  // Stack pointer decode; top_idx wraps when empty but is never used then.
  assign count     = sp;
  assign empty     = (sp == SP_W'(0));
  assign full      = (sp == SP_W'(DEPTH));
  assign top_idx   = DEPTH_BITS'(sp - SP_W'(1));
  assign top_entry = mem[top_idx];

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush && !empty) state_next = DRAIN;
      DRAIN:   if (sp <= SP_W'(1))  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drain outputs
  always_comb begin
    unassign_valid   = 1'b0;
    unassign_var_idx = '0;
    busy             = 1'b0;
    if (state == DRAIN) begin
      unassign_valid   = 1'b1;
      unassign_var_idx = top_entry[ENTRY_W-1:1];
      busy             = 1'b1;
    end
  end

  // Plain push only (no flush, no simultaneous pop) writes storage.
  assign mem_we = reset && (state == IDLE) && !flush && push_en && !pop_req && !full;

  // Entry storage, no reset needed
  always_ff @(posedge clock) begin
    if (mem_we) mem[DEPTH_BITS'(sp)] <= {push_var_idx, push_val};
  end

  // Stack pointer, pop result registers and sticky overflow
  always_ff @(posedge clock) begin
    if (!reset) begin
      sp          <= '0;
      pop_valid   <= 1'b0;
      pop_var_idx <= '0;
      pop_val     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      if (state == DRAIN) begin
        if (push_en) overflow <= 1'b1;
        if (!empty)  sp <= sp - SP_W'(1);
      end else if (flush) begin
        // Backtrack wins; any concurrent push is lost.
        if (push_en) overflow <= 1'b1;
      end else if (push_en && pop_req) begin
        // Bypass: pushed entry goes straight back out, stack untouched.
        pop_valid   <= 1'b1;
        pop_var_idx <= push_var_idx;
        pop_val     <= push_val;
      end else if (push_en) begin
        if (full) overflow <= 1'b1;
        else      sp <= sp + SP_W'(1);
      end else if (pop_req && !empty) begin
        pop_valid   <= 1'b1;
        pop_var_idx <= top_entry[ENTRY_W-1:1];
        pop_val     <= top_entry[0];
        sp          <= sp - SP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imply_stack.sv
// Testbench for imply_stack: directed test-plan sequences followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_imply_stack;

  localparam int unsigned VB = 9;
  localparam int unsigned D  = 4;
  localparam int unsigned DB = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          push_en;
  logic [VB-1:0] push_var_idx;
  logic          push_val;
  logic          pop_req;
  logic          flush;
  logic          pop_valid;
  logic [VB-1:0] pop_var_idx;
  logic          pop_val;
  logic          unassign_valid;
  logic [VB-1:0] unassign_var_idx;
  logic          busy;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [DB:0]   count;

  imply_stack #(.MAX_VARS_BITS(VB), .DEPTH(D), .DEPTH_BITS(DB)) dut (
    .clock(clock), .reset(reset), .push_en(push_en), .push_var_idx(push_var_idx),
    .push_val(push_val), .pop_req(pop_req), .flush(flush), .pop_valid(pop_valid),
    .pop_var_idx(pop_var_idx), .pop_val(pop_val), .unassign_valid(unassign_valid),
    .unassign_var_idx(unassign_var_idx), .busy(busy), .empty(empty), .full(full),
    .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue holding {idx,val}, back = top of stack.
  logic [VB:0]   stk[$];
  bit            m_drain;
  bit            m_ovf;
  bit            m_pv;
  logic [VB-1:0] m_pidx;
  logic          m_pval;
  bit            m_pchk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit pu, input logic [VB-1:0] idx,
                            input bit v, input bit po, input bit fl);
    logic [VB:0] e;
    m_pv   = 1'b0;
    m_pchk = 1'b0;
    if (!rst) begin
      stk.delete();
      m_drain = 1'b0;
      m_ovf   = 1'b0;
      m_pidx  = '0;
      m_pval  = 1'b0;
      m_pchk  = 1'b1;
    end else if (m_drain) begin
      if (pu) m_ovf = 1'b1;
      e = stk.pop_back();
      if (stk.size() == 0) m_drain = 1'b0;
    end else if (fl) begin
      if (pu) m_ovf = 1'b1;
      if (stk.size() > 0) m_drain = 1'b1;
    end else if (pu && po) begin
      m_pv = 1'b1; m_pidx = idx; m_pval = v;
    end else if (pu) begin
      if (stk.size() < D) stk.push_back({idx, v});
      else m_ovf = 1'b1;
    end else if (po && stk.size() > 0) begin
      e = stk.pop_back();
      m_pv = 1'b1; m_pidx = e[VB:1]; m_pval = e[0];
    end
    if (m_pv) m_pchk = 1'b1;
  endtask

  task automatic compare_all();
    logic [VB:0] t;
    t = '0;
    if (m_drain) t = stk[stk.size()-1];
    check("count",     32'(count),          32'(stk.size()));
    check("empty",     32'(empty),          32'(stk.size() == 0));
    check("full",      32'(full),           32'(stk.size() == D));
    check("overflow",  32'(overflow),       32'(m_ovf));
    check("pop_valid", 32'(pop_valid),      32'(m_pv));
    check("busy",      32'(busy),           32'(m_drain));
    check("unassign_valid", 32'(unassign_valid), 32'(m_drain));
    check("unassign_idx",   32'(unassign_var_idx), 32'(t[VB:1]));
    if (m_pchk) begin
      check("pop_idx", 32'(pop_var_idx), 32'(m_pidx));
      check("pop_val", 32'(pop_val),     32'(m_pval));
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input bit rst, input bit pu, input int idx, input bit v,
                      input bit po, input bit fl);
    reset        = rst;
    push_en      = pu;
    push_var_idx = VB'(idx);
    push_val     = v;
    pop_req      = po;
    flush        = fl;
    @(posedge clock);
    model_edge(rst, pu, VB'(idx), v, po, fl);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input int idx, input bit v);
    step(1, 1, idx, v, 0, 0);
  endtask

  task automatic pop();
    step(1, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_drain = 0; m_ovf = 0; m_pv = 0; m_pidx = '0; m_pval = 0; m_pchk = 0;
    reset = 0; push_en = 0; push_var_idx = '0; push_val = 0; pop_req = 0; flush = 0;

    // Reset 2 cycles, release
    do_reset();
    do_reset();
    idle();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);

    // LIFO order
    push(5, 1); push(9, 0); push(3, 1);
    pop(); check("lifo0_idx", 32'(pop_var_idx), 32'd3); check("lifo0_val", 32'(pop_val), 32'd1);
    pop(); check("lifo1_idx", 32'(pop_var_idx), 32'd9); check("lifo1_val", 32'(pop_val), 32'd0);
    pop(); check("lifo2_idx", 32'(pop_var_idx), 32'd5); check("lifo2_val", 32'(pop_val), 32'd1);
    pop(); check("pop_empty_valid", 32'(pop_valid), 32'd0);

    // Fill to DEPTH, overflow, bypass while full
    push(10, 0); push(11, 1); push(12, 0); push(13, 1);
    check("full_after4", 32'(full), 32'd1);
    push(14, 0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag",  32'(overflow), 32'd1);
    step(1, 1, 7, 0, 1, 0);
    check("bypass_full_idx", 32'(pop_var_idx), 32'd7);
    check("bypass_full_cnt", 32'(count), 32'd4);
    do_reset();

    // Flush drain with a push during drain
    push(1, 0); push(2, 1); push(4, 0);
    step(1, 0, 0, 0, 0, 1);
    check("drain0", 32'(unassign_var_idx), 32'd4);
    step(1, 1, 20, 1, 0, 0);
    check("drain1", 32'(unassign_var_idx), 32'd2);
    idle();
    check("drain2", 32'(unassign_var_idx), 32'd1);
    check("drain_ovf", 32'(overflow), 32'd1);
    idle();
    check("drain_done_cnt",  32'(count), 32'd0);
    check("drain_done_busy", 32'(busy),  32'd0);
    do_reset();

    // Flush when empty, bypass when empty
    step(1, 0, 0, 0, 0, 1);
    check("flush_empty_busy", 32'(busy), 32'd0);
    step(1, 1, 33, 1, 1, 0);
    check("bypass_empty_pv",  32'(pop_valid), 32'd1);
    check("bypass_empty_idx", 32'(pop_var_idx), 32'd33);

    // Reset mid-drain
    push(6, 1); push(7, 0); push(8, 1);
    step(1, 0, 0, 0, 0, 1);
    idle();
    do_reset();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_uv",   32'(unassign_valid), 32'd0);
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, pu, po, fl;
      r  = ($urandom_range(0, 199) != 0);
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 40);
      fl = ($urandom_range(0, 99) < 5);
      step(r, pu, int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), po, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
